ps2_port: RTL and testbench
===========================

PS2_PORT -- requirements
Module: ps2_port

Interface
REQ-001 SHALL have parameter DATA_PORT, default 8'h00, meaning the CPU port address for the scancode data/pop.
REQ-002 SHALL have parameter STAT_PORT, default 8'h01, meaning the CPU port address for status/control.
REQ-003 SHALL have parameter TIMEOUT, default 25000, meaning the clk cycles allowed between PS/2 falling edges inside a frame.
REQ-004 SHALL have port clk, input, 1, the single clock (CPU clock domain).
REQ-005 SHALL have port rst, input, 1, a synchronous active-high reset sampled on posedge clk.
REQ-006 SHALL have port ps2_clk, input, 1, the raw PS/2 clock, asynchronous.
REQ-007 SHALL have port ps2_dat, input, 1, the raw PS/2 data, asynchronous.
REQ-008 SHALL have port pin_pa, input, 8, the CPU port address.
REQ-009 SHALL have port pin_po, input, 8, the CPU port write data.
REQ-010 SHALL have port pin_pw, input, 1, the CPU port write strobe, one clk wide.
REQ-011 SHALL have port pin_pi, output, 8, the port read data to the CPU.
REQ-012 SHALL have port pin_intr, output, 1, the interrupt request, level.

Function
REQ-013 SHALL pass ps2_clk/ps2_dat through 2-flop synchronizers; an edge is a falling edge of synced ps2_clk (1 then 0); data SHALL be sampled on that edge.
REQ-014 Receiver FSM SHALL have states IDLE and SHIFT; IDLE->SHIFT on the first falling edge (start bit captured); SHIFT SHALL count 11 bits total, then return to IDLE.
REQ-015 Frame format SHALL be start=0, 8 data bits LSB first, odd parity (data plus parity has an odd number of ones), stop=1.
REQ-016 A frame with valid start, parity and stop SHALL push its data byte into the FIFO in the clk after the stop bit is sampled.
REQ-017 Any invalid field SHALL discard the frame and set sticky frame_err.
REQ-018 In SHIFT, a timeout counter SHALL reset on each falling edge; reaching TIMEOUT SHALL abort to IDLE, discard the partial frame and set frame_err.
REQ-019 FIFO SHALL be 8 entries deep with a 3-bit wrapping rd/wr pointer and a 4-bit count (0..8).
REQ-020 Push while full SHALL drop the byte and set sticky overflow; the FIFO contents SHALL be unchanged.
REQ-021 A pin_pw with pin_pa==DATA_PORT SHALL pop one entry; a pop when empty SHALL be ignored; pin_po is ignored on this port.
REQ-022 Simultaneous pop and push in one clk SHALL leave the count unchanged and SHALL NOT set overflow, including when full.
REQ-023 A pin_pw with pin_pa==STAT_PORT SHALL act as follows: pin_po[0]=1 flushes the FIFO (count=0, pointers=0) and clears overflow and frame_err; pin_po[1] writes irq_en; a push in the same clk is lost.
REQ-024 pin_pi SHALL be combinational from pin_pa: DATA_PORT gives the FIFO head (8'h00 if empty); STAT_PORT gives {3'b000, irq_en, frame_err, overflow, full, !empty}; any other address gives 8'h00.
REQ-025 pin_intr SHALL be registered as irq_en & !empty, and so lags the FIFO state by one clk.

Reset
REQ-026 rst SHALL force: FSM=IDLE, bit counter=0, timeout=0, FIFO empty, pointers=0, overflow=0, frame_err=0, irq_en=0, pin_intr=0, and synchronizers to 1.
REQ-027 rst mid-frame SHALL discard the partial frame; the receiver SHALL resynchronize on the next start bit.
REQ-028 pin_pi SHALL read STAT_PORT as 8'h00 during and after reset.

Structure
REQ-029 Package ps2_port_pkg SHALL hold the FSM state enum, the status bit positions, and the FIFO depth/pointer-width constants.
REQ-030 The frame receiver (synchronizers, FSM, timeout, parity check) SHALL be sub-module ps2_rx, emitting a 1-clk valid strobe, 8-bit data, and a 1-clk err strobe; FIFO and port decode SHALL stay in ps2_port.

Verification
REQ-031 Frame 0x1C (parity 0), then STAT_PORT write 8'h02 -> STAT reads 8'h11, DATA reads 8'h1C, pin_intr=1; DATA pop -> STAT 8'h10, pin_intr=0 next clk.
REQ-032 Frame 0x1C with parity 1 -> FIFO stays empty, STAT reads 8'h08; STAT write 8'h01 -> STAT 8'h00.
REQ-033 Nine frames 0x01..0x09, no pops -> STAT 8'h07; eight pops return 0x01..0x08; 0x09 is absent.
REQ-034 FIFO full, DATA pop in the same clk as the push of 0x0A -> count stays 8, overflow=0, last entry 0x0A.
REQ-035 5 PS/2 edges then idle TIMEOUT+1 clk -> frame_err=1 and FSM IDLE; next frame 0x5A is received correctly.
REQ-036 rst asserted after bit 4 of a frame, then a full 0x29 frame -> only 0x29 in the FIFO, STAT 8'h01.

Source files
------------

// File: rtl/ps2_port_pkg.sv
// Shared types and constants for the PS/2 keyboard port: receiver FSM
// states, status register bit positions and FIFO geometry.
package ps2_port_pkg;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    localparam int FRAME_BITS = 11;

    localparam int FIFO_DEPTH = 8;
    localparam int PTR_W      = 3;
    localparam int CNT_W      = 4;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_FRAME_ERR = 3;
    localparam int STAT_IRQ_EN    = 4;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the raw lines, shifts in 11-bit frames on
// falling ps2_clk edges and emits one-clk valid/err strobes per frame.
module ps2_rx
    import ps2_port_pkg::*;
#(
    parameter int TIMEOUT = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       valid,
    output logic [7:0] data,
    output logic       err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [3:0]      LAST_BIT = 4'(FRAME_BITS - 1);

    logic [1:0] raw_lines;
    logic [1:0] synced;
    logic       clk_s;
    logic       dat_s;
    logic       fall;

    assign raw_lines = {ps2_dat, ps2_clk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= raw_lines[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign synced[gi] = sync_reg;
        end
    endgenerate

    assign clk_s = synced[0];
    assign dat_s = synced[1];

    rx_state_t       state_reg,   state_next;
    logic [3:0]      bit_cnt_reg, bit_cnt_next;
    logic [TO_W-1:0] to_cnt_reg,  to_cnt_next;
    logic [9:0]      shift_reg,   shift_next;
    logic [7:0]      data_reg,    data_next;
    logic            valid_reg,   valid_next;
    logic            err_reg,     err_next;
    logic            clk_prev_reg;

    assign fall = clk_prev_reg & ~clk_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RX_IDLE;
            bit_cnt_reg  <= '0;
            to_cnt_reg   <= '0;
            shift_reg    <= '0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
            clk_prev_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            to_cnt_reg   <= to_cnt_next;
            shift_reg    <= shift_next;
            data_reg     <= data_next;
            valid_reg    <= valid_next;
            err_reg      <= err_next;
            clk_prev_reg <= clk_s;
        end
    end

    // shift_reg collects start..parity LSB-first; the stop bit is checked live.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        to_cnt_next  = to_cnt_reg;
        shift_next   = shift_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        err_next     = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                if (fall) begin
                    shift_next   = {dat_s, shift_reg[9:1]};
                    bit_cnt_next = 4'd1;
                    to_cnt_next  = '0;
                    state_next   = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (fall) begin
                    to_cnt_next = '0;
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next   = RX_IDLE;
                        bit_cnt_next = '0;
                        if (!shift_reg[0] && (^shift_reg[9:1]) && dat_s) begin
                            valid_next = 1'b1;
                            data_next  = shift_reg[8:1];
                        end else begin
                            err_next = 1'b1;
                        end
                    end else begin
                        shift_next   = {dat_s, shift_reg[9:1]};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end else if (to_cnt_reg == TO_LAST) begin
                    state_next   = RX_IDLE;
                    bit_cnt_next = '0;
                    to_cnt_next  = '0;
                    err_next     = 1'b1;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign valid = valid_reg;
    assign data  = data_reg;
    assign err   = err_reg;

endmodule

// File: rtl/ps2_port.sv
// CPU-facing PS/2 keyboard port: 8-deep scancode FIFO, data/status port
// decode and a level interrupt while data is pending.
module ps2_port
    import ps2_port_pkg::*;
#(
    parameter logic [7:0] DATA_PORT = 8'h00,
    parameter logic [7:0] STAT_PORT = 8'h01,
    parameter int         TIMEOUT   = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] pin_pa,
    input  logic [7:0] pin_po,
    input  logic       pin_pw,
    output logic [7:0] pin_pi,
    output logic       pin_intr
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic       rx_valid;
    logic       rx_err;
    logic [7:0] rx_data;

    ps2_rx #(
        .TIMEOUT(TIMEOUT)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .valid  (rx_valid),
        .data   (rx_data),
        .err    (rx_err)
    );

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             overflow_reg;
    logic             frame_err_reg;
    logic             irq_en_reg;
    logic             intr_reg;

    logic empty, full;
    logic pop_req, stat_wr, flush;
    logic do_pop, do_push, ovf_set;
    logic [7:0] stat_vec;
    logic unused_po;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_CNT);
    assign pop_req = pin_pw && (pin_pa == DATA_PORT);
    assign stat_wr = pin_pw && (pin_pa == STAT_PORT);
    assign flush   = stat_wr && pin_po[0];

    // A pop in the same clk frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop_req && !empty && !flush;
    assign do_push = rx_valid && !flush && (!full || do_pop);
    assign ovf_set = rx_valid && !flush && full && !do_pop;

    assign unused_po = ^pin_po[7:2];

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_reg] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            irq_en_reg    <= 1'b0;
            intr_reg      <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_reg    <= '0;
                rd_ptr_reg    <= '0;
                count_reg     <= '0;
                overflow_reg  <= 1'b0;
                frame_err_reg <= 1'b0;
            end else begin
                if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                if (do_push && !do_pop) begin
                    count_reg <= count_reg + 1'b1;
                end else if (do_pop && !do_push) begin
                    count_reg <= count_reg - 1'b1;
                end
                if (ovf_set) overflow_reg  <= 1'b1;
                if (rx_err)  frame_err_reg <= 1'b1;
            end
            if (stat_wr) irq_en_reg <= pin_po[1];
            intr_reg <= irq_en_reg & !empty;
        end
    end

    always_comb begin
        stat_vec                 = '0;
        stat_vec[STAT_NOT_EMPTY] = !empty;
        stat_vec[STAT_FULL]      = full;
        stat_vec[STAT_OVERFLOW]  = overflow_reg;
        stat_vec[STAT_FRAME_ERR] = frame_err_reg;
        stat_vec[STAT_IRQ_EN]    = irq_en_reg;
    end

    // Reads are forced to zero while reset is held so the CPU never sees stale state.
    always_comb begin
        pin_pi = 8'h00;
        if (!rst) begin
            if (pin_pa == DATA_PORT) begin
                pin_pi = empty ? 8'h00 : fifo_mem[rd_ptr_reg];
            end else if (pin_pa == STAT_PORT) begin
                pin_pi = stat_vec;
            end
        end
    end

    assign pin_intr = intr_reg;

endmodule

// File: tb/tb_ps2_port.sv
// Bench for ps2_port: bit-bangs PS/2 frames, keeps expected scancodes in a
// queue and compares them against FIFO pops and status reads.
module tb_ps2_port;
    import ps2_port_pkg::*;

    localparam int         TO   = 200;
    localparam int         HALF = 20;
    localparam logic [7:0] DP   = 8'h00;
    localparam logic [7:0] SP   = 8'h01;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] pin_pa = 8'h00;
    logic [7:0] pin_po = 8'h00;
    logic       pin_pw = 1'b0;
    logic [7:0] pin_pi;
    logic       pin_intr;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rd;
    logic       found;

    always #5 clk = ~clk;

    ps2_port #(
        .DATA_PORT(DP),
        .STAT_PORT(SP),
        .TIMEOUT  (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .pin_pa  (pin_pa),
        .pin_po  (pin_po),
        .pin_pw  (pin_pw),
        .pin_pi  (pin_pi),
        .pin_intr(pin_intr)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end else begin
            $display("ok   %s: %02h", tag, got);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic bad_par);
        logic par;
        par = (~^d) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        ps2_bit(1'b1);
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        if (!bad_par && exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
        drive_frame(d, bad_par);
    endtask

    task automatic port_write(input logic [7:0] pa, input logic [7:0] po);
        @(negedge clk);
        pin_pa = pa;
        pin_po = po;
        pin_pw = 1'b1;
        @(posedge clk);
        #1;
        pin_pw = 1'b0;
    endtask

    task automatic read_port(input logic [7:0] pa, output logic [7:0] v);
        pin_pa = pa;
        #1;
        v = pin_pi;
    endtask

    task automatic check_stat(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        read_port(SP, v);
        check(tag, v, exp);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        logic [7:0] v;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        read_port(DP, v);
        check(tag, v, e);
        port_write(DP, 8'hFF);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_stat("stat_in_reset", 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check_stat("stat_after_reset", 8'h00);
        check("intr_after_reset", {7'b0, pin_intr}, 8'h00);
        read_port(DP, rd);
        check("data_empty", rd, 8'h00);
        port_write(DP, 8'h55);
        check_stat("pop_empty_ignored", 8'h00);

        // single frame, interrupt enable, pop and interrupt lag
        send_frame(8'h1C, 1'b0);
        port_write(SP, 8'h02);
        @(posedge clk); #1;
        check_stat("t031_stat", 8'h11);
        check("t031_intr", {7'b0, pin_intr}, 8'h01);
        pop_check("t031_pop");
        check_stat("t031_stat_after_pop", 8'h10);
        check("t031_intr_lag", {7'b0, pin_intr}, 8'h01);
        @(posedge clk); #1;
        check("t031_intr_clear", {7'b0, pin_intr}, 8'h00);

        // bad parity
        port_write(SP, 8'h01);
        check_stat("t032_flushed", 8'h00);
        send_frame(8'h1C, 1'b1);
        check_stat("t032_parity_err", 8'h08);
        port_write(SP, 8'h01);
        check_stat("t032_cleared", 8'h00);

        // overflow
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
        check_stat("t033_full_ovf", 8'h07);
        for (int i = 0; i < 8; i++) pop_check($sformatf("t033_pop%0d", i));
        pop_check("t033_ninth_absent");
        check_stat("t033_ovf_sticky", 8'h04);
        port_write(SP, 8'h01);

        // pop coincident with push into a full FIFO
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0);
        check_stat("t034_full", 8'h03);
        found = 1'b0;
        fork
            drive_frame(8'h0A, 1'b0);
            begin
                for (int k = 0; k < 1000 && !found; k++) begin
                    @(negedge clk);
                    if (dut.u_rx.valid_reg) begin
                        found = 1'b1;
                        pin_pa = DP;
                        #1;
                        check("t034_head", pin_pi, exp_q[0]);
                        pin_pw = 1'b1;
                        @(posedge clk); #1;
                        pin_pw = 1'b0;
                    end
                end
                check("t034_sync", {7'b0, found}, 8'h01);
            end
        join
        void'(exp_q.pop_front());
        exp_q.push_back(8'h0A);
        check_stat("t034_still_full_no_ovf", 8'h03);
        for (int i = 0; i < 8; i++) pop_check($sformatf("t034_pop%0d", i));
        check_stat("t034_empty", 8'h00);

        // inter-edge timeout
        ps2_bit(1'b0);
        ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        repeat (TO / 2) @(negedge clk);
        check_stat("t035_before_timeout", 8'h00);
        check("t035_still_shift", 8'(dut.u_rx.state_reg), 8'(RX_SHIFT));
        repeat (TO + 8) @(negedge clk);
        check_stat("t035_timeout_err", 8'h08);
        check("t035_idle", 8'(dut.u_rx.state_reg), 8'(RX_IDLE));
        send_frame(8'h5A, 1'b0);
        check_stat("t035_recv_stat", 8'h09);
        pop_check("t035_pop");
        port_write(SP, 8'h01);

        // reset mid-frame
        ps2_bit(1'b0);
        ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_stat("t036_stat_in_reset", 8'h00);
        rst = 1'b0;
        exp_q.delete();
        send_frame(8'h29, 1'b0);
        check_stat("t036_stat", 8'h01);
        pop_check("t036_pop");
        check_stat("t036_empty", 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
